// File: rtl/up_count_timer.sv
// -----------------------------------------------------------------------------
// up_count_timer
//
// Programmable up-counting interval timer, the count-up companion to the down
// counter. A start clears the count, latches the terminal value and enters RUN.
// In RUN the count advances by STEP each cycle until the next step would pass
// the latched terminal value. At that point a one-cycle tc pulse is produced.
// The timer then either reloads 0 and keeps running (AUTO_RELOAD=1) or holds
// its last value in DONE (AUTO_RELOAD=0). pause freezes the count while high.
//
// Parameters
//   WIDTH        counter / limit width in bits
//   STEP         increment per counting cycle, 1 .. 2**WIDTH-1
//   AUTO_RELOAD  1 = free-run, 0 = one-shot
//
// Ports
//   clk    in   rising-edge clock
//   rst    in   synchronous active-high reset, overrides every other input
//   start  in   (re)start: out <= 0, latch limit, enter RUN (legal in any state)
//   pause  in   level; freezes the count while high in RUN
//   limit  in   terminal value, sampled only on an accepted start
//   out    out  current count (registered)
//   busy   out  high in RUN or PAUSE
//   tc     out  one-cycle terminal pulse, coincident with the terminal update
//   done   out  high in DONE (one-shot only)
// -----------------------------------------------------------------------------
module up_count_timer #(
  parameter int WIDTH       = 4,
  parameter int STEP        = 1,
  parameter bit AUTO_RELOAD = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             pause,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             tc,
  output logic             done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_PAUSE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [WIDTH:0] STEP_EXT = (WIDTH + 1)'(STEP);

  logic [1:0]       state;
  logic [WIDTH-1:0] limit_q;
  logic [WIDTH:0]   nxt;

  // The candidate count carries one extra bit, so a step past the top of the
  // WIDTH-bit range is seen as "beyond limit" and does not wrap back to a small
  // value.
  assign nxt = {1'b0, out} + STEP_EXT;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments, so every right-hand
    // side reads the pre-edge value no matter how the statements are ordered.
    if (rst) begin
      state   <= S_IDLE;
      out     <= '0;
      limit_q <= '0;
      tc      <= 1'b0;
    end else if (start) begin
      state   <= S_RUN;
      out     <= '0;
      limit_q <= limit;
      tc      <= 1'b0;
    end else begin
      // tc is a pulse. Every path clears it unless this edge is a terminal one.
      tc <= 1'b0;
      case (state)
        S_RUN: begin
          if (pause) begin
            state <= S_PAUSE;
          end else if (nxt <= {1'b0, limit_q}) begin
            out <= nxt[WIDTH-1:0];
          end else begin
            tc <= 1'b1;
            if (AUTO_RELOAD) begin
              out <= '0;
            end else begin
              state <= S_DONE;
            end
          end
        end
        // The release edge only re-enters RUN. Counting resumes on the edge
        // after it, so the pause costs no step and adds none.
        S_PAUSE: begin
          if (!pause) begin
            state <= S_RUN;
          end
        end
        // IDLE and DONE hold everything. Only start or rst leaves them.
        default: begin
        end
      endcase
    end
  end

  // NOTE: these status flags are continuous decodes of registered state, so no
  // latch can form and no input reaches an output combinationally.
  assign busy = (state == S_RUN) || (state == S_PAUSE);
  assign done = (state == S_DONE);

endmodule
